cp0: RTL and testbench

- Coprocessor-0 register file and exception arbiter. Sits beside the M stage.
- Consumes the exception code and branch-delay flag that the decode stage produces and carries down the pipeline, plus the six hardware interrupt lines.
- Decides when to take an interrupt or exception, records the victim PC in EPC, and raises IntReq so the pipeline flushes and the PC is redirected to the handler.
- Serves mfc0/mtc0/eret.

---
 rtl/cp0_if.sv | 25 ++
 rtl/cp0.sv | 93 +++++++++
 tb/tb_cp0.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_if.sv
// Bus bundle between the M stage and the CP0 register file / exception arbiter.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PCM;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, WE, PCM, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  IntReq, EPCOut, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, PCM, BDIn, ExcCodeIn, HWInt, EXLClr,
    output IntReq, EPCOut, DOut
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId registers plus the interrupt/exception
// arbiter that raises IntReq combinationally and records the victim state.
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_0001
) (
  input  logic  Clk,
  input  logic  Reset,
  cp0_if.slave  bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [31:0] victim_pc;

  // Live HWInt, not the registered IP, so an interrupt is seen the cycle it arrives.
  assign int_pend  = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_pend  = (bus.ExcCodeIn != 5'd0) & ~exl_q;
  assign int_req   = int_pend | exc_pend;
  assign victim_pc = bus.BDIn ? (bus.PCM - 32'd4) : bus.PCM;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = bus.HWInt;
    exc_d = exc_q;
    epc_d = epc_q;

    if (int_req) begin
      // An interrupted mtc0 must not commit, so WE is ignored here.
      exl_d = 1'b1;
      exc_d = int_pend ? 5'd0 : bus.ExcCodeIn;
      bd_d  = bus.BDIn;
      epc_d = victim_pc & 32'hFFFF_FFFC;
    end else begin
      if (bus.WE && bus.A2 == 5'd12) begin
        im_d  = bus.DIn[15:10];
        exl_d = bus.DIn[1];
        ie_d  = bus.DIn[0];
      end
      if (bus.WE && bus.A2 == 5'd14) begin
        epc_d = bus.DIn & 32'hFFFF_FFFC;
      end
      if (bus.EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      im_q  <= 6'd0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= 6'd0;
      exc_q <= 5'd0;
      epc_q <= 32'd0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    case (bus.A1)
      5'd12:   bus.DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13:   bus.DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
      5'd14:   bus.DOut = epc_q;
      5'd15:   bus.DOut = PRID;
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.IntReq = int_req;
  assign bus.EPCOut = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: vector table driven through an expected-result queue, plus
// hand-written sequences for asynchronous reset and EPC wraparound.
module tb_cp0;

  localparam logic [31:0] PRID = 32'h0000_0001;

  logic Clk;
  logic Reset;
  cp0_if bus();

  cp0 #(.PRID(PRID)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pcm;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        exlclr;
    logic        e_intreq;
    logic [31:0] e_dout;
    logic [31:0] e_epc;
  } vec_t;

  typedef struct {
    int          idx;
    logic        intreq;
    logic [31:0] dout;
    logic [31:0] epc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic [4:0] a1, logic [4:0] a2, logic [31:0] din, logic we,
                              logic [31:0] pcm, logic bd, logic [4:0] exc, logic [5:0] hw,
                              logic exlclr, logic e_intreq, logic [31:0] e_dout,
                              logic [31:0] e_epc);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pcm = pcm; v.bd = bd;
    v.exc = exc; v.hw = hw; v.exlclr = exlclr;
    v.e_intreq = e_intreq; v.e_dout = e_dout; v.e_epc = e_epc;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.A1 = v.a1; bus.A2 = v.a2; bus.DIn = v.din; bus.WE = v.we;
    bus.PCM = v.pcm; bus.BDIn = v.bd; bus.ExcCodeIn = v.exc;
    bus.HWInt = v.hw; bus.EXLClr = v.exlclr;
  endtask

  task automatic idle();
    drive(mk(5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0));
  endtask

  initial begin
    exp_t e;
    string nm;

    //            a1  a2  din            we  pcm           bd exc  hw     clr  intreq dout           epc
    vecs.push_back(mk(12, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0,        32'h0));
    vecs.push_back(mk(13, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0,        32'h0));
    vecs.push_back(mk(14, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0,        32'h0));
    vecs.push_back(mk(15, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, PRID,         32'h0));
    vecs.push_back(mk(12, 12, 32'hFFFF_FFFF, 1, 32'h0,      0, 0,  6'd0,  0,   0, 32'h0,        32'h0));
    vecs.push_back(mk(12, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0000_FC03, 32'h0));
    vecs.push_back(mk(13, 13, 32'hFFFF_FFFF, 1, 32'h0,      0, 0,  6'd0,  0,   0, 32'h0,        32'h0));
    vecs.push_back(mk(13, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0,        32'h0));
    vecs.push_back(mk(12, 12, 32'h0000_0401, 1, 32'h0,      0, 0,  6'd0,  1,   0, 32'h0000_FC03, 32'h0));
    vecs.push_back(mk(12, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0000_0401, 32'h0));
    vecs.push_back(mk(12, 0, 32'h0,        0, 32'h0000_3010, 0, 0, 6'd1,  0,   1, 32'h0000_0401, 32'h0));
    vecs.push_back(mk(14, 0, 32'h0,        0, 32'h0,        0, 0,  6'd1,  0,   0, 32'h0000_3010, 32'h0000_3010));
    vecs.push_back(mk(13, 0, 32'h0,        0, 32'h0,        0, 0,  6'd1,  0,   0, 32'h0000_0400, 32'h0000_3010));
    vecs.push_back(mk(12, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0000_0403, 32'h0000_3010));
    vecs.push_back(mk(12, 12, 32'h0,       1, 32'h0,        0, 0,  6'd0,  1,   0, 32'h0000_0403, 32'h0000_3010));
    vecs.push_back(mk(12, 14, 32'hDEAD_BEEF, 1, 32'h0000_3008, 1, 10, 6'd0, 0, 1, 32'h0,        32'h0000_3010));
    vecs.push_back(mk(13, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h8000_0028, 32'h0000_3004));
    vecs.push_back(mk(14, 0, 32'h0,        0, 32'h0,        0, 4,  6'd0,  0,   0, 32'h0000_3004, 32'h0000_3004));
    vecs.push_back(mk(12, 0, 32'h0,        0, 32'h0,        0, 4,  6'd0,  1,   0, 32'h0000_0002, 32'h0000_3004));
    vecs.push_back(mk(12, 0, 32'h0,        0, 32'h0000_3020, 0, 4, 6'd0,  0,   1, 32'h0,        32'h0000_3004));
    vecs.push_back(mk(13, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0000_0010, 32'h0000_3020));
    vecs.push_back(mk(14, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0000_3020, 32'h0000_3020));
    vecs.push_back(mk(15, 12, 32'h0000_1001, 1, 32'h0,      0, 0,  6'd0,  1,   0, PRID,         32'h0000_3020));
    vecs.push_back(mk(12, 0, 32'h0,        0, 32'h0000_3040, 1, 12, 6'd4, 0,   1, 32'h0000_1001, 32'h0000_3020));
    vecs.push_back(mk(13, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h8000_1000, 32'h0000_303C));
    vecs.push_back(mk(14, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, 32'h0000_303C, 32'h0000_303C));
    vecs.push_back(mk(14, 14, 32'h1234_5677, 1, 32'h0,      0, 0,  6'd0,  0,   0, 32'h0000_303C, 32'h0000_303C));
    vecs.push_back(mk(14, 15, 32'hFFFF_FFFF, 1, 32'h0,      0, 0,  6'd0,  0,   0, 32'h1234_5674, 32'h1234_5674));
    vecs.push_back(mk(15, 0, 32'h0,        0, 32'h0,        0, 0,  6'd0,  0,   0, PRID,         32'h1234_5674));

    Reset = 1'b1;
    idle();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clk);
      #1;
      drive(vecs[i]);
      e.idx = i; e.intreq = vecs[i].e_intreq; e.dout = vecs[i].e_dout; e.epc = vecs[i].e_epc;
      sb.push_back(e);
      @(negedge Clk);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty vec%0d: got 0 entries required 1", i);
      end else begin
        e = sb.pop_front();
        nm = $sformatf("vec%0d_intreq", e.idx);
        chk32(nm, {31'd0, bus.IntReq}, {31'd0, e.intreq});
        nm = $sformatf("vec%0d_dout", e.idx);
        chk32(nm, bus.DOut, e.dout);
        nm = $sformatf("vec%0d_epcout", e.idx);
        chk32(nm, bus.EPCOut, e.epc);
      end
    end

    // Asynchronous reset mid-cycle: state must clear before the next edge.
    @(posedge Clk);
    #1;
    idle();
    bus.A1 = 5'd14;
    #1;
    chk32("pre_reset_epc", bus.DOut, 32'h1234_5674);
    #1 Reset = 1'b1;
    #1 chk32("areset_epcout", bus.EPCOut, 32'h0);
    chk32("areset_epc", bus.DOut, 32'h0);
    bus.A1 = 5'd12;
    #1 chk32("areset_sr", bus.DOut, 32'h0);
    bus.A1 = 5'd13;
    #1 chk32("areset_cause", bus.DOut, 32'h0);
    bus.ExcCodeIn = 5'd3;
    #1 chk32("areset_exc_intreq", {31'd0, bus.IntReq}, 32'd1);
    bus.ExcCodeIn = 5'd0;
    bus.HWInt = 6'h3F;
    #1 chk32("areset_hw_masked", {31'd0, bus.IntReq}, 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    idle();

    // Exception in a delay slot at PC 0: EPC wraps to 0xFFFF_FFFC.
    @(posedge Clk);
    #1;
    bus.ExcCodeIn = 5'd1; bus.BDIn = 1'b1; bus.PCM = 32'h0; bus.A1 = 5'd14;
    @(negedge Clk);
    chk32("wrap_intreq", {31'd0, bus.IntReq}, 32'd1);
    @(posedge Clk);
    #1;
    idle();
    bus.A1 = 5'd14;
    #1 chk32("wrap_epc_read", bus.DOut, 32'hFFFF_FFFC);
    chk32("wrap_epcout", bus.EPCOut, 32'hFFFF_FFFC);
    bus.A1 = 5'd13;
    #1 chk32("wrap_cause", bus.DOut, 32'h8000_0004);
    bus.A1 = 5'd12;
    #1 chk32("wrap_sr_exl", bus.DOut, 32'h0000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
